// File: rtl/keypad_decoder_if.sv
// Keypad-side signal bundle: row sense and column drive, plus the decoded event
// strobes and data that feed the calculator sequencer.
interface keypad_decoder_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       is_num;
  logic       is_op;
  logic       is_eq;
  logic       is_clr;
  logic [3:0] num_val;
  logic [1:0] op_val;

  modport master (
    output row_in,
    input  col_out, is_num, is_op, is_eq, is_clr, num_val, op_val
  );

  modport slave (
    input  row_in,
    output col_out, is_num, is_op, is_eq, is_clr, num_val, op_val
  );
endinterface

// File: rtl/keypad_decoder.sv
// 4x4 matrix keypad scanner with row synchroniser, press/release debounce and
// key decode producing one single-cycle event per physical press.
//   state     | meaning
//   SCAN      | drive one column per dwell period, look for a low row
//   DEB_PRESS | captured row pattern must stay stable for DEBOUNCE cycles
//   EMIT      | one cycle with the decoded strobe high
//   WAIT_REL  | all rows must read high for DEBOUNCE cycles before rescanning
module keypad_decoder #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 50000
) (
  input  logic            clk,
  input  logic            rst,
  keypad_decoder_if.slave kp
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    EMIT      = 2'd2,
    WAIT_REL  = 2'd3
  } state_t;

  state_t        state_q;
  logic [3:0]    row_m_q;
  logic [3:0]    row_s_q;
  logic [DW-1:0] dwell_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    col_q;
  logic [3:0]    cap_q;
  logic          is_num_q;
  logic          is_op_q;
  logic          is_eq_q;
  logic          is_clr_q;
  logic [3:0]    num_val_q;
  logic [1:0]    op_val_q;

  logic          one_zero_d;
  logic [1:0]    row_idx_d;
  logic          num_d;
  logic          op_d;
  logic          eq_d;
  logic          clr_d;
  logic [3:0]    num_val_d;
  logic [1:0]    op_val_d;

  // Decode of the captured pattern; col_q is frozen from capture until release.
  always_comb begin
    one_zero_d = 1'b1;
    row_idx_d  = 2'd0;
    num_d      = 1'b0;
    op_d       = 1'b0;
    eq_d       = 1'b0;
    clr_d      = 1'b0;
    num_val_d  = 4'd0;
    op_val_d   = 2'd0;
    case (cap_q)
      4'b1110: row_idx_d = 2'd0;
      4'b1101: row_idx_d = 2'd1;
      4'b1011: row_idx_d = 2'd2;
      4'b0111: row_idx_d = 2'd3;
      default: one_zero_d = 1'b0;
    endcase
    if (col_q == 2'd3) begin
      op_d     = 1'b1;
      op_val_d = row_idx_d;
    end else if (row_idx_d == 2'd3) begin
      case (col_q)
        2'd0:    clr_d = 1'b1;
        2'd1:    num_d = 1'b1;
        default: eq_d  = 1'b1;
      endcase
    end else begin
      num_d     = 1'b1;
      num_val_d = 4'(row_idx_d) * 4'd3 + 4'(col_q) + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      row_m_q   <= 4'hF;
      row_s_q   <= 4'hF;
      dwell_q   <= '0;
      cnt_q     <= '0;
      col_q     <= 2'd0;
      cap_q     <= 4'hF;
      is_num_q  <= 1'b0;
      is_op_q   <= 1'b0;
      is_eq_q   <= 1'b0;
      is_clr_q  <= 1'b0;
      num_val_q <= 4'd0;
      op_val_q  <= 2'd0;
    end else begin
      row_m_q  <= kp.row_in;
      row_s_q  <= row_m_q;
      is_num_q <= 1'b0;
      is_op_q  <= 1'b0;
      is_eq_q  <= 1'b0;
      is_clr_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (dwell_q == DW'(SCAN_DIV - 1)) begin
            dwell_q <= '0;
            if (row_s_q != 4'hF) begin
              cap_q   <= row_s_q;
              cnt_q   <= '0;
              state_q <= DEB_PRESS;
            end else begin
              col_q <= col_q + 2'd1;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (row_s_q != cap_q) begin
            dwell_q <= '0;
            state_q <= SCAN;
          end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
            cnt_q   <= CW'(DEBOUNCE);
            state_q <= EMIT;
            // Strobes are raised here so they are high exactly during EMIT.
            if (one_zero_d) begin
              is_num_q <= num_d;
              is_op_q  <= op_d;
              is_eq_q  <= eq_d;
              is_clr_q <= clr_d;
              if (num_d) num_val_q <= num_val_d;
              if (op_d)  op_val_q  <= op_val_d;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        EMIT: begin
          cnt_q   <= '0;
          state_q <= WAIT_REL;
        end
        WAIT_REL: begin
          if (row_s_q != 4'hF) begin
            cnt_q <= '0;
          end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
            cnt_q   <= '0;
            dwell_q <= '0;
            col_q   <= col_q + 2'd1;
            state_q <= SCAN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign kp.col_out = ~(4'b0001 << col_q);
  assign kp.is_num  = is_num_q;
  assign kp.is_op   = is_op_q;
  assign kp.is_eq   = is_eq_q;
  assign kp.is_clr  = is_clr_q;
  assign kp.num_val = num_val_q;
  assign kp.op_val  = op_val_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder with a keypad model that shorts each
// pressed key's row to its column whenever that column is driven low.
module tb_keypad_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] key_mask = 16'h0;
  logic [3:0]  row_model;
  int          n_total = 0;
  int          n_bad = 0;
  int          evq[$];

  keypad_decoder_if kp();

  keypad_decoder #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && !kp.col_out[c]) row_model[r] = 1'b0;
  end
  assign kp.row_in = row_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Event log: 16+digit, 32+op, 48 eq, 64 clr.
  always @(negedge clk) begin
    chk("onehot", 32'($countones({kp.is_num, kp.is_op, kp.is_eq, kp.is_clr}) <= 1), 32'd1);
    if (kp.is_num) evq.push_back(16 + int'(kp.num_val));
    if (kp.is_op)  evq.push_back(32 + int'(kp.op_val));
    if (kp.is_eq)  evq.push_back(48);
    if (kp.is_clr) evq.push_back(64);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int r, input int c, input int hold, input int settle);
    key_mask[r*4+c] = 1'b1;
    cycles(hold);
    key_mask = 16'h0;
    cycles(settle);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] col);
    int k;
    k = 0;
    while (kp.col_out !== col && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(kp.col_out), 32'(col));
  endtask

  task automatic expect_one(input string tag, input int ev);
    chk({tag, "_count"}, 32'(evq.size()), 32'd1);
    if (evq.size() > 0) chk({tag, "_ev"}, 32'(evq[0]), 32'(ev));
    evq.delete();
  endtask

  initial begin
    logic [3:0] e;
    int seq_exp[5];
    int k;
    seq_exp = '{17, 32, 18, 48, 64};

    cycles(3);
    rst = 1'b0;
    chk("rst_col", 32'(kp.col_out), 32'hE);
    chk("rst_pulses", 32'({kp.is_num, kp.is_op, kp.is_eq, kp.is_clr}), 32'd0);
    chk("rst_num", 32'(kp.num_val), 32'd0);
    chk("rst_op", 32'(kp.op_val), 32'd0);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      e = 4'hF;
      e[(i/4)%4] = 1'b0;
      chk("idle_col", 32'(kp.col_out), 32'(e));
    end
    chk("idle_events", 32'(evq.size()), 32'd0);
    chk("idle_num", 32'(kp.num_val), 32'd0);

    // '7' at r2,c0
    key_mask[8] = 1'b1;
    cycles(30);
    key_mask = 16'h0;
    k = 0;
    while (kp.col_out === 4'b1110 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("resume_col", 32'(kp.col_out), 32'hD);
    cycles(20);
    expect_one("key7", 23);
    chk("key7_held", 32'(kp.num_val), 32'd7);

    // '-' at r1,c3 with bounce
    for (int b = 0; b < 5; b++) begin
      key_mask[7] = (b % 2 == 0);
      @(negedge clk);
    end
    press(1, 3, 40, 30);
    expect_one("minus", 33);
    chk("minus_opval", 32'(kp.op_val), 32'd1);

    press(0, 0, 4, 40);
    chk("glitch_events", 32'(evq.size()), 32'd0);
    chk("glitch_num", 32'(kp.num_val), 32'd7);

    press(0, 0, 40, 30);
    press(0, 3, 40, 30);
    press(0, 1, 40, 30);
    press(3, 2, 40, 30);
    press(3, 0, 40, 30);
    chk("seq_count", 32'(evq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < evq.size()) chk("seq_ev", 32'(evq[i]), 32'(seq_exp[i]));
    evq.delete();
    chk("seq_op", 32'(kp.op_val), 32'd0);

    // '2' and '8' together in column 1
    key_mask[1] = 1'b1;
    key_mask[9] = 1'b1;
    cycles(40);
    key_mask = 16'h0;
    cycles(30);
    chk("multi_events", 32'(evq.size()), 32'd0);
    chk("multi_num", 32'(kp.num_val), 32'd2);
    press(1, 1, 40, 30);
    expect_one("key5", 21);

    // '9' held across a reset issued during DEB_PRESS
    wait_col("rst_wait_c0", 4'b1110);
    key_mask[10] = 1'b1;
    wait_col("rst_wait_c2", 4'b1011);
    cycles(6);
    chk("rst_pre_events", 32'(evq.size()), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_col", 32'(kp.col_out), 32'hE);
    chk("rst_mid_num", 32'(kp.num_val), 32'd0);
    @(negedge clk);
    chk("rst_mid_events", 32'(evq.size()), 32'd0);
    cycles(60);
    key_mask = 16'h0;
    cycles(30);
    expect_one("key9", 25);
    chk("key9_num", 32'(kp.num_val), 32'd9);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
